// File: rtl/cbd_sampler.sv
// Centered-binomial sampler for ML-KEM noise polynomials.
// Consumes the PRF bit stream (bit 0 of each word first) and emits one
// 256-coefficient polynomial in [0, Q-1], coefficient i at poly_o[12*i +: 12].
//
// Handshakes (both ports): a transfer happens on a rising clk_i edge where
// valid and ready are both high. in_ready_o is derived only from registered
// state, so it never depends on in_valid_i. poly_valid_o stays high with
// poly_o stable until poly_ready_i is seen high at a clock edge.
//
// Legal parameters: ETA in {2,3}; 512*ETA divisible by DATA_W;
// BUF_W >= DATA_W + 2*ETA - 1.
module cbd_sampler #(
  parameter int ETA    = 2,
  parameter int DATA_W = 64,
  parameter int BUF_W  = 128,
  parameter int Q      = 3329
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [DATA_W-1:0]   in_data_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [256*12-1:0]   poly_o,
  output logic                poly_valid_o,
  input  logic                poly_ready_i,
  output logic                busy_o,
  output logic [1:0]          state_o
);

  localparam int SW     = 2 * ETA;
  localparam int NWORDS = 512 * ETA / DATA_W;
  localparam int WCW    = $clog2(NWORDS + 1);
  localparam int BCW    = $clog2(BUF_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            state_q;
  logic [BUF_W-1:0]  buf_q;
  logic [BCW-1:0]    bcnt_q;
  logic [8:0]        ci_q;
  logic [WCW-1:0]    wcnt_q;
  logic [256*12-1:0] poly_q;
  logic              poly_valid_q;
  logic              busy_q;

  logic              push;
  logic              take;
  logic [2:0]        pop_a;
  logic [2:0]        pop_b;
  logic [11:0]       coef;
  logic [BUF_W-1:0]  buf_shift;
  logic [BCW-1:0]    pos;
  logic [BUF_W-1:0]  word_ext;
  logic [BUF_W-1:0]  buf_next;
  logic [BCW-1:0]    bcnt_next;

  // Ready needs room for a whole word above the valid bits and a word budget left.
  assign in_ready_o = (state_q == ST_SAMPLE) &&
                      (bcnt_q <= BCW'(BUF_W - DATA_W)) &&
                      (wcnt_q < WCW'(NWORDS));

  assign poly_o       = poly_q;
  assign poly_valid_o = poly_valid_q;
  assign busy_o       = busy_q;
  assign state_o      = state_q;

  // Coefficient from the lowest 2*ETA buffered bits: popcount(low) - popcount(high) mod Q.
  always_comb begin
    pop_a = '0;
    pop_b = '0;
    for (int j = 0; j < ETA; j++) begin
      pop_a = pop_a + 3'(buf_q[j]);
      pop_b = pop_b + 3'(buf_q[ETA + j]);
    end
    if (pop_a >= pop_b) coef = 12'(pop_a - pop_b);
    else                coef = 12'(Q) - 12'(pop_b - pop_a);
  end

  // Next buffer contents: drop consumed field first, then place the new word
  // directly above the surviving valid bits so nothing is lost or duplicated.
  always_comb begin
    push      = in_valid_i && in_ready_o;
    take      = (state_q == ST_SAMPLE) && (bcnt_q >= BCW'(SW)) && !ci_q[8];
    buf_shift = take ? (buf_q >> SW) : buf_q;
    pos       = take ? (bcnt_q - BCW'(SW)) : bcnt_q;
    word_ext  = BUF_W'(in_data_i) << pos;
    buf_next  = push ? (buf_shift | word_ext) : buf_shift;
    bcnt_next = bcnt_q + (push ? BCW'(DATA_W) : '0) - (take ? BCW'(SW) : '0);
  end

  // Control FSM with its datapath registers and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      buf_q        <= '0;
      bcnt_q       <= '0;
      ci_q         <= '0;
      wcnt_q       <= '0;
      poly_q       <= '0;
      poly_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_SAMPLE;
            busy_q  <= 1'b1;
            buf_q   <= '0;
            bcnt_q  <= '0;
            ci_q    <= '0;
            wcnt_q  <= '0;
          end
        end
        ST_SAMPLE: begin
          buf_q  <= buf_next;
          bcnt_q <= bcnt_next;
          if (push) wcnt_q <= wcnt_q + WCW'(1);
          if (take) begin
            poly_q[12*ci_q[7:0] +: 12] <= coef;
            ci_q <= ci_q + 9'd1;
          end
          // All 256 coefficients are written; publish on the following edge.
          if (ci_q[8]) begin
            state_q      <= ST_DONE;
            poly_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (poly_ready_i) begin
            state_q      <= ST_IDLE;
            poly_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          poly_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cbd_sampler.sv
// Directed bench for cbd_sampler: one ETA=2 and one ETA=3 instance share a
// muxed stimulus/observation path; sel picks the active instance.
module tb_cbd_sampler;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic start_s, valid_s, pready_s;
  logic [63:0] data_s;

  logic ready2, ready3, pvalid2, pvalid3, busy2, busy3;
  logic [1:0] st2, st3;
  logic [3071:0] poly2, poly3;

  logic ready_m, pvalid_m, busy_m;
  logic [1:0] st_m;
  logic [3071:0] poly_m;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cbd_sampler #(.ETA(2), .DATA_W(64), .BUF_W(128), .Q(3329)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start_s & ~sel), .in_data_i(data_s),
    .in_valid_i(valid_s & ~sel), .in_ready_o(ready2), .poly_o(poly2),
    .poly_valid_o(pvalid2), .poly_ready_i(pready_s & ~sel), .busy_o(busy2),
    .state_o(st2)
  );

  cbd_sampler #(.ETA(3), .DATA_W(64), .BUF_W(128), .Q(3329)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .start_i(start_s & sel), .in_data_i(data_s),
    .in_valid_i(valid_s & sel), .in_ready_o(ready3), .poly_o(poly3),
    .poly_valid_o(pvalid3), .poly_ready_i(pready_s & sel), .busy_o(busy3),
    .state_o(st3)
  );

  assign ready_m  = sel ? ready3  : ready2;
  assign pvalid_m = sel ? pvalid3 : pvalid2;
  assign busy_m   = sel ? busy3   : busy2;
  assign st_m     = sel ? st3     : st2;
  assign poly_m   = sel ? poly3   : poly2;

  typedef struct {
    int          eta;
    logic [5:0]  field;
    int          stall;
    logic [11:0] exp_coef;
  } vec_t;

  vec_t vecs[6];

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_poly(input string name, input logic [3071:0] got, input logic [3071:0] exp);
    int first;
    total++;
    if (got !== exp) begin
      bad++;
      first = 0;
      for (int i = 255; i >= 0; i--)
        if (got[12*i +: 12] !== exp[12*i +: 12]) first = i;
      $display("FAIL %s: coef[%0d] got %0d expected %0d", name, first,
               got[12*first +: 12], exp[12*first +: 12]);
    end
  endtask

  function automatic logic [1535:0] make_stream(input int eta, input logic [5:0] field);
    logic [1535:0] s;
    s = '0;
    for (int k = 0; k < 512 * eta; k++) s[k] = field[k % (2 * eta)];
    return s;
  endfunction

  function automatic logic [1535:0] rand_stream();
    logic [1535:0] s;
    for (int w = 0; w < 24; w++) s[w*64 +: 64] = {$urandom(), $urandom()};
    return s;
  endfunction

  // Reference: coefficient i = sum(bits[2e*i .. 2e*i+e-1]) - sum(next e bits), mod Q.
  function automatic logic [3071:0] model_poly(input int eta, input logic [1535:0] s);
    logic [3071:0] p;
    int a, b, v;
    for (int i = 0; i < 256; i++) begin
      a = 0;
      b = 0;
      for (int j = 0; j < eta; j++) begin
        a += int'(s[2*eta*i + j]);
        b += int'(s[2*eta*i + eta + j]);
      end
      v = a - b;
      if (v < 0) v = 3329 + v;
      p[12*i +: 12] = 12'(v);
    end
    return p;
  endfunction

  function automatic logic [3071:0] const_poly(input logic [11:0] c);
    logic [3071:0] p;
    for (int i = 0; i < 256; i++) p[12*i +: 12] = c;
    return p;
  endfunction

  // Start one polynomial, feed the stream (extra junk words offered after the
  // last one), and wait for poly_valid. lat counts edges after the start edge.
  task automatic run_poly(input int eta, input logic [1535:0] stream, input int stall_pct,
                          output int acc, output int lat, output logic ready_late,
                          output logic done);
    int nwords;
    int widx;
    logic xfer;
    nwords = 8 * eta;
    sel = (eta == 3);
    acc = 0;
    lat = 0;
    widx = 0;
    ready_late = 1'b0;
    done = 1'b0;
    @(negedge clk);
    start_s = 1'b1;
    valid_s = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_s = 1'b0;
    for (int cyc = 1; cyc <= 3000 && !done; cyc++) begin
      if ($urandom_range(99) >= 32'(stall_pct)) begin
        valid_s = 1'b1;
        data_s  = (widx < nwords) ? stream[widx*64 +: 64] : {$urandom(), $urandom()};
      end else begin
        valid_s = 1'b0;
      end
      xfer = valid_s && ready_m;
      @(posedge clk);
      if (xfer) begin
        widx++;
        acc++;
      end
      #1;
      if (acc >= nwords && ready_m) ready_late = 1'b1;
      if (pvalid_m) begin
        lat = cyc;
        done = 1'b1;
      end
      @(negedge clk);
    end
    valid_s = 1'b0;
  endtask

  task automatic release_poly();
    @(negedge clk);
    pready_s = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    pready_s = 1'b0;
  endtask

  task automatic check_run(input string tag, input int eta, input int stall, input int acc,
                           input int lat, input logic ready_late, input logic done);
    check_val({tag, " done"}, 32'(done), 32'd1);
    check_val({tag, " words_accepted"}, 32'(acc), 32'(8 * eta));
    check_val({tag, " ready_after_last_word"}, 32'(ready_late), 32'd0);
    if (stall == 0) check_val({tag, " latency"}, 32'(lat), 32'd258);
    check_val({tag, " state_done"}, 32'(st_m), 32'd2);
  endtask

  initial begin
    int acc, lat;
    logic ready_late, done;
    logic [1535:0] s;
    logic [3071:0] saved;
    logic hold_ok;
    int widx;
    logic xfer;

    vecs[0] = '{eta: 2, field: 6'b000000, stall: 0, exp_coef: 12'd0};
    vecs[1] = '{eta: 2, field: 6'b001100, stall: 0, exp_coef: 12'd3327};
    vecs[2] = '{eta: 2, field: 6'b000011, stall: 0, exp_coef: 12'd2};
    vecs[3] = '{eta: 2, field: 6'b001111, stall: 0, exp_coef: 12'd0};
    vecs[4] = '{eta: 3, field: 6'b000111, stall: 0, exp_coef: 12'd3};
    vecs[5] = '{eta: 3, field: 6'b111000, stall: 0, exp_coef: 12'd3326};

    // Clock/reset.
    rst = 1'b1;
    sel = 1'b0;
    start_s = 1'b0;
    valid_s = 1'b0;
    pready_s = 1'b0;
    data_s = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset ready", 32'(ready2), 32'd0);
    check_val("reset poly_valid", 32'(pvalid2), 32'd0);
    check_val("reset busy", 32'(busy2), 32'd0);
    check_val("reset state", 32'(st2), 32'd0);
    check_poly("reset poly", poly2, '0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven constant patterns.
    for (int t = 0; t < 6; t++) begin
      s = make_stream(vecs[t].eta, vecs[t].field);
      run_poly(vecs[t].eta, s, vecs[t].stall, acc, lat, ready_late, done);
      check_run($sformatf("vec%0d", t), vecs[t].eta, vecs[t].stall, acc, lat, ready_late, done);
      check_poly($sformatf("vec%0d poly", t), poly_m, const_poly(vecs[t].exp_coef));
      if (vecs[t].eta == 3) check_val($sformatf("vec%0d coef10", t), 32'(poly_m[120 +: 12]),
                                      32'(vecs[t].exp_coef));
      release_poly();
    end

    // Random ETA=2 stream with 50% input stalls.
    s = rand_stream();
    run_poly(2, s, 50, acc, lat, ready_late, done);
    check_run("rand2", 2, 50, acc, lat, ready_late, done);
    check_poly("rand2 poly", poly_m, model_poly(2, s));

    // Hold in DONE while start pulses; then release.
    saved = model_poly(2, s);
    hold_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      pready_s = 1'b0;
      start_s = c[0];
      @(posedge clk);
      #1;
      if (poly_m !== saved || pvalid_m !== 1'b1 || st_m !== 2'd2) hold_ok = 1'b0;
    end
    @(negedge clk);
    start_s = 1'b0;
    check_val("done hold", 32'(hold_ok), 32'd1);
    pready_s = 1'b1;
    @(posedge clk);
    #1;
    check_val("release state", 32'(st_m), 32'd0);
    check_val("release busy", 32'(busy_m), 32'd0);
    check_val("release poly_valid", 32'(pvalid_m), 32'd0);
    check_poly("idle retains poly", poly_m, saved);
    @(negedge clk);
    pready_s = 1'b0;

    // Random ETA=3 stream with stalls; coefficient 10 straddles words 0 and 1.
    s = rand_stream();
    run_poly(3, s, 30, acc, lat, ready_late, done);
    check_run("rand3", 3, 30, acc, lat, ready_late, done);
    check_poly("rand3 poly", poly_m, model_poly(3, s));
    saved = model_poly(3, s);
    check_val("rand3 coef10", 32'(poly_m[120 +: 12]), 32'(saved[120 +: 12]));
    release_poly();

    // Abort with reset after 101 generate edges (ci = 100).
    sel = 1'b0;
    s = rand_stream();
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s = 1'b0;
    widx = 0;
    for (int cyc = 1; cyc <= 101; cyc++) begin
      valid_s = 1'b1;
      data_s = s[widx*64 +: 64];
      xfer = ready_m;
      @(posedge clk);
      if (xfer) widx++;
      @(negedge clk);
    end
    valid_s = 1'b0;
    check_val("pre-abort state", 32'(st_m), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("abort state", 32'(st_m), 32'd0);
    check_poly("abort poly", poly_m, '0);
    check_val("abort ready", 32'(ready_m), 32'd0);
    check_val("abort poly_valid", 32'(pvalid_m), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fresh polynomial after the abort.
    s = rand_stream();
    run_poly(2, s, 0, acc, lat, ready_late, done);
    check_run("post_abort", 2, 0, acc, lat, ready_late, done);
    check_poly("post_abort poly", poly_m, model_poly(2, s));
    release_poly();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
